// File: rtl/rv_decode_pkg.sv
// Shared types for the RV32I/RV64I decode stage: opcode map, immediate formats,
// skid-buffer states and the opcode-to-format lookup.
package rv_decode_pkg;

    typedef enum logic [6:0] {
        LOAD      = 7'h03,
        MISC_MEM  = 7'h0F,
        OP_IMM    = 7'h13,
        AUIPC     = 7'h17,
        OP_IMM_32 = 7'h1B,
        STORE     = 7'h23,
        OP        = 7'h33,
        LUI       = 7'h37,
        OP_32     = 7'h3B,
        BRANCH    = 7'h63,
        JALR      = 7'h67,
        JAL       = 7'h6F,
        SYSTEM    = 7'h73
    } rv_opcode_e;

    typedef enum logic [2:0] {R, I, S, B, U, J} rv_format_e;

    typedef enum logic [1:0] {SKID_EMPTY, SKID_ONE, SKID_FULL} skid_state_e;

    // Unknown opcodes fall back to R so they carry a zero immediate.
    function automatic rv_format_e decode_format(input logic [6:0] opcode);
        rv_format_e fmt;
        fmt = R;
        case (opcode)
            OP_IMM, LOAD, JALR, SYSTEM, OP_IMM_32: fmt = I;
            STORE:                                 fmt = S;
            BRANCH:                                fmt = B;
            LUI, AUIPC:                            fmt = U;
            JAL:                                   fmt = J;
            default:                               fmt = R;
        endcase
        return fmt;
    endfunction

endpackage

// File: rtl/rv_skid_buffer.sv
// Valid/ready output buffer of one or two entries; head entry drives the output.
// state      | meaning
// SKID_EMPTY | no entry held, out_valid low
// SKID_ONE   | head holds the oldest entry
// SKID_FULL  | head and tail both hold entries, in_ready low
module rv_skid_buffer
    import rv_decode_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    skid_state_e      state_q;
    skid_state_e      state_d;
    logic [WIDTH-1:0] head_q;
    logic [WIDTH-1:0] tail_q;
    logic             ready_q;
    logic             acc;
    logic             pop;
    logic             load_head;
    logic             load_tail;
    logic             shift;

    assign out_valid = (state_q != SKID_EMPTY);
    assign out_data  = head_q;
    // ready_q stays low in reset so in_ready rises on the first edge after release.
    assign in_ready  = (DEPTH == 1) ? (ready_q && (!out_valid || out_ready)) : ready_q;

    always_comb begin
        state_d   = state_q;
        load_head = 1'b0;
        load_tail = 1'b0;
        shift     = 1'b0;
        acc       = in_valid && in_ready;
        pop       = out_valid && out_ready;
        if (flush) begin
            state_d = SKID_EMPTY;
        end else begin
            case (state_q)
                SKID_EMPTY: begin
                    if (acc) begin
                        state_d   = SKID_ONE;
                        load_head = 1'b1;
                    end
                end
                SKID_ONE: begin
                    if (acc && pop) begin
                        load_head = 1'b1;
                    end else if (acc) begin
                        state_d   = SKID_FULL;
                        load_tail = 1'b1;
                    end else if (pop) begin
                        state_d = SKID_EMPTY;
                    end
                end
                SKID_FULL: begin
                    if (pop) begin
                        state_d = SKID_ONE;
                        shift   = 1'b1;
                    end
                end
                default: state_d = SKID_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SKID_EMPTY;
            ready_q <= 1'b0;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            state_q <= state_d;
            ready_q <= (state_d != SKID_FULL);
            if (load_head) begin
                head_q <= in_data;
            end else if (shift) begin
                head_q <= tail_q;
            end
            if (load_tail) begin
                tail_q <= in_data;
            end
        end
    end

endmodule

// File: rtl/rv_inst_decode_stage.sv
// Registered RV32I/RV64I decode stage: builds the immediate and illegal-encoding flag
// ahead of the skid buffer; field outputs are slices of the registered instruction.
module rv_inst_decode_stage
    import rv_decode_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int PC_WIDTH   = 32,
    parameter int SKID_DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [31:0]         in_inst,
    input  logic [PC_WIDTH-1:0] in_pc,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [PC_WIDTH-1:0] out_pc,
    output logic [31:0]         out_inst,
    output logic [6:0]          out_opcode,
    output logic [4:0]          out_rd,
    output logic [4:0]          out_rs1,
    output logic [4:0]          out_rs2,
    output logic [2:0]          out_funct3,
    output logic [6:0]          out_funct7,
    output logic [11:0]         out_funct12,
    output logic [XLEN-1:0]     out_imm,
    output logic                out_decode_err
);

    localparam bit RV64  = (XLEN == 64);
    localparam int PAY_W = PC_WIDTH + 32 + XLEN + 1;

    rv_format_e       fmt;
    logic [31:0]      imm32;
    logic [XLEN-1:0]  imm;
    logic             err;
    logic [6:0]       funct7;
    logic [2:0]       funct3;
    logic [PAY_W-1:0] pay_in;
    logic [PAY_W-1:0] pay_out;

    assign funct7 = in_inst[31:25];
    assign funct3 = in_inst[14:12];

    // Build a 32-bit sign-extended value first, then widen from bit 31 to XLEN.
    always_comb begin
        fmt   = decode_format(in_inst[6:0]);
        imm32 = '0;
        case (fmt)
            I:       imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
            S:       imm32 = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
            B:       imm32 = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25],
                              in_inst[11:8], 1'b0};
            U:       imm32 = {in_inst[31:12], 12'b0};
            J:       imm32 = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20],
                              in_inst[30:21], 1'b0};
            default: imm32 = '0;
        endcase
        imm = {{(XLEN-31){imm32[31]}}, imm32[30:0]};
    end

    always_comb begin
        err = (in_inst[1:0] != 2'b11);
        case (in_inst[6:0])
            OP: begin
                if (funct7 == 7'h20) begin
                    if (funct3 != 3'd0 && funct3 != 3'd5) err = 1'b1;
                end else if (funct7 != 7'h00) begin
                    err = 1'b1;
                end
            end
            OP_IMM: begin
                if (funct3 == 3'd1 || funct3 == 3'd5) begin
                    if (RV64) begin
                        if (in_inst[31:26] != 6'h00 && in_inst[31:26] != 6'h10) err = 1'b1;
                    end else begin
                        if (funct7 != 7'h00 && funct7 != 7'h20) err = 1'b1;
                    end
                end
            end
            OP_32, OP_IMM_32: begin
                if (!RV64) err = 1'b1;
            end
            LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, MISC_MEM, SYSTEM: ;
            default: err = 1'b1;
        endcase
    end

    assign pay_in = {in_pc, in_inst, imm, err};

    rv_skid_buffer #(
        .WIDTH (PAY_W),
        .DEPTH (SKID_DEPTH)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (pay_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (pay_out)
    );

    assign {out_pc, out_inst, out_imm, out_decode_err} = pay_out;

    assign out_opcode  = out_inst[6:0];
    assign out_rd      = out_inst[11:7];
    assign out_rs1     = out_inst[19:15];
    assign out_rs2     = out_inst[24:20];
    assign out_funct3  = out_inst[14:12];
    assign out_funct7  = out_inst[31:25];
    assign out_funct12 = out_inst[31:20];

endmodule

// File: tb/tb_rv_inst_decode_stage.sv
// Drives an XLEN=32 and an XLEN=64 decode stage with identical traffic and checks
// both against an occupancy/queue model and arithmetic immediate/legality rules.
module tb_rv_inst_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in_inst = '0;
    logic [31:0] in_pc = '0;

    logic        rdy_a, ov_a, err_a;
    logic [31:0] pc_a, inst_a, imm_a;
    logic [6:0]  opc_a, f7_a;
    logic [4:0]  rd_a, rs1_a, rs2_a;
    logic [2:0]  f3_a;
    logic [11:0] f12_a;

    logic        rdy_b, ov_b, err_b;
    logic [31:0] pc_b, inst_b;
    logic [63:0] imm_b;
    logic [6:0]  opc_b, f7_b;
    logic [4:0]  rd_b, rs1_b, rs2_b;
    logic [2:0]  f3_b;
    logic [11:0] f12_b;

    rv_inst_decode_stage #(.XLEN(32), .PC_WIDTH(32), .SKID_DEPTH(2)) dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy_a),
        .in_inst(in_inst), .in_pc(in_pc), .out_valid(ov_a), .out_ready(out_ready),
        .out_pc(pc_a), .out_inst(inst_a), .out_opcode(opc_a), .out_rd(rd_a),
        .out_rs1(rs1_a), .out_rs2(rs2_a), .out_funct3(f3_a), .out_funct7(f7_a),
        .out_funct12(f12_a), .out_imm(imm_a), .out_decode_err(err_a)
    );

    rv_inst_decode_stage #(.XLEN(64), .PC_WIDTH(32), .SKID_DEPTH(2)) dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy_b),
        .in_inst(in_inst), .in_pc(in_pc), .out_valid(ov_b), .out_ready(out_ready),
        .out_pc(pc_b), .out_inst(inst_b), .out_opcode(opc_b), .out_rd(rd_b),
        .out_rs1(rs1_b), .out_rs2(rs2_b), .out_funct3(f3_b), .out_funct7(f7_b),
        .out_funct12(f12_b), .out_imm(imm_b), .out_decode_err(err_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    ent_t        q[$];
    bit          model_rdy = 1'b0;
    bit          rdy_known = 1'b0;
    int          checks = 0;
    int          failures = 0;
    logic [31:0] next_pc = 32'h1000;

    logic [6:0] op_list [13] = '{7'h03, 7'h0F, 7'h13, 7'h17, 7'h1B, 7'h23, 7'h33,
                                 7'h37, 7'h3B, 7'h63, 7'h67, 7'h6F, 7'h73};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Immediate as a signed integer: top instruction bit carries negative weight.
    function automatic logic [63:0] ref_imm(input logic [31:0] w);
        longint v;
        v = 0;
        case (w[6:0])
            7'h13, 7'h03, 7'h67, 7'h73, 7'h1B:
                v = longint'(w[30:20]) - longint'(w[31]) * 2048;
            7'h23:
                v = longint'({w[30:25], w[11:7]}) - longint'(w[31]) * 2048;
            7'h63:
                v = longint'(w[7]) * 2048 + longint'(w[30:25]) * 32 + longint'(w[11:8]) * 2
                    - longint'(w[31]) * 4096;
            7'h37, 7'h17:
                v = longint'(w[30:12]) * 4096 - longint'(w[31]) * 64'sd2147483648;
            7'h6F:
                v = longint'(w[19:12]) * 4096 + longint'(w[20]) * 2048
                    + longint'(w[30:21]) * 2 - longint'(w[31]) * 1048576;
            default: v = 0;
        endcase
        return v;
    endfunction

    function automatic logic ref_err(input logic [31:0] w, input bit rv64);
        logic [6:0] f7;
        logic [2:0] f3;
        f7 = w[31:25];
        f3 = w[14:12];
        if (w[1:0] != 2'b11) return 1'b1;
        case (w[6:0])
            7'h33: return !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
            7'h13: begin
                if (f3 == 3'd1 || f3 == 3'd5)
                    return rv64 ? !(w[31:26] == 6'h00 || w[31:26] == 6'h10)
                                : !(f7 == 7'h00 || f7 == 7'h20);
                return 1'b0;
            end
            7'h3B, 7'h1B: return !rv64;
            7'h03, 7'h23, 7'h63, 7'h67, 7'h6F, 7'h37, 7'h17, 7'h0F, 7'h73: return 1'b0;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [31:0] gen_inst();
        logic [31:0] w;
        int          sel;
        w   = $urandom();
        sel = $urandom_range(0, 15);
        if (sel < 13) w[6:0] = op_list[sel];
        if ($urandom_range(0, 1) == 1) w[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
        if ($urandom_range(0, 5) == 0) w[31:26] = 6'h10;
        return w;
    endfunction

    task automatic check_outputs();
        check("valid_32", ov_a, q.size() != 0);
        check("valid_64", ov_b, q.size() != 0);
        if (rdy_known) begin
            check("ready_32", rdy_a, model_rdy);
            check("ready_64", rdy_b, model_rdy);
        end
        if (q.size() != 0) begin
            ent_t        e;
            logic [63:0] im;
            e  = q[0];
            im = ref_imm(e.inst);
            check("pc_32", pc_a, e.pc);
            check("inst_32", inst_a, e.inst);
            check("opcode_32", opc_a, e.inst[6:0]);
            check("rd_32", rd_a, e.inst[11:7]);
            check("rs1_32", rs1_a, e.inst[19:15]);
            check("rs2_32", rs2_a, e.inst[24:20]);
            check("funct3_32", f3_a, e.inst[14:12]);
            check("funct7_32", f7_a, e.inst[31:25]);
            check("funct12_32", f12_a, e.inst[31:20]);
            check("imm_32", imm_a, im[31:0]);
            check("err_32", err_a, ref_err(e.inst, 1'b0));
            check("pc_64", pc_b, e.pc);
            check("inst_64", inst_b, e.inst);
            check("rd_64", rd_b, e.inst[11:7]);
            check("funct12_64", f12_b, e.inst[31:20]);
            check("imm_64", imm_b, im);
            check("err_64", err_b, ref_err(e.inst, 1'b1));
        end
    endtask

    // One clock: drive at negedge, check at negedge+1, update the model at posedge.
    task automatic cycle(input bit v, input logic [31:0] w, input bit ordy, input bit fl);
        bit          acc;
        bit          pop;
        logic [31:0] pc;
        pc = next_pc;
        @(negedge clk);
        in_valid  = v;
        in_inst   = w;
        in_pc     = pc;
        out_ready = ordy;
        flush     = fl;
        #1;
        check_outputs();
        acc = v && rdy_known && model_rdy && !fl;
        pop = (q.size() != 0) && ordy && !fl;
        @(posedge clk);
        if (fl) begin
            q.delete();
        end else begin
            if (pop) void'(q.pop_front());
            if (acc) q.push_back('{pc: pc, inst: w});
        end
        if (acc) next_pc = next_pc + 4;
        rdy_known = 1'b1;
        model_rdy = (q.size() < 2);
    endtask

    initial begin
        @(posedge clk);
        #1;
        check("reset_valid_32", ov_a, 1'b0);
        check("reset_valid_64", ov_b, 1'b0);
        check("reset_pc", pc_a, 32'h0);
        check("reset_imm", imm_b, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        rdy_known = 1'b1;
        model_rdy = 1'b1;

        cycle(1'b1, 32'hFFF10093, 1'b1, 1'b0);
        #1;
        check("addi_rd", rd_a, 5'd1);
        check("addi_rs1", rs1_a, 5'd2);
        check("addi_funct3", f3_a, 3'd0);
        check("addi_imm", imm_a, 32'hFFFFFFFF);
        check("addi_err", err_a, 1'b0);

        cycle(1'b1, 32'hFFDFF06F, 1'b1, 1'b0);
        #1;
        check("jal_imm64", imm_b, 64'hFFFFFFFFFFFFFFFC);
        check("jal_err64", err_b, 1'b0);

        cycle(1'b1, 32'h0020803B, 1'b1, 1'b0);
        #1;
        check("addw_err32", err_a, 1'b1);
        check("addw_err64", err_b, 1'b0);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);

        for (int k = 0; k < 3; k++) begin
            cycle(1'b1, gen_inst(), 1'b0, 1'b0);
            #1;
            if (k == 1) check("bp_in_ready", rdy_a, 1'b0);
        end
        for (int k = 0; k < 3; k++) cycle(1'b0, 32'h0, 1'b1, 1'b0);

        cycle(1'b1, gen_inst(), 1'b0, 1'b0);
        cycle(1'b1, gen_inst(), 1'b0, 1'b0);
        cycle(1'b1, gen_inst(), 1'b0, 1'b1);
        #1;
        check("flush_valid", ov_a, 1'b0);
        check("flush_ready", rdy_a, 1'b1);
        cycle(1'b1, gen_inst(), 1'b1, 1'b0);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);

        cycle(1'b1, gen_inst(), 1'b0, 1'b0);
        cycle(1'b1, gen_inst(), 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid_32", ov_a, 1'b0);
        check("async_rst_valid_64", ov_b, 1'b0);
        check("async_rst_pc", pc_a, 32'h0);
        q.delete();
        rdy_known = 1'b0;
        model_rdy = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        rdy_known = 1'b1;
        model_rdy = 1'b1;
        cycle(1'b1, 32'h00500113, 1'b1, 1'b0);
        #1;
        check("post_rst_valid", ov_a, 1'b1);
        check("post_rst_pc", pc_a, next_pc - 32'd4);

        for (int k = 0; k < 400; k++) begin
            cycle($urandom_range(0, 3) != 0, gen_inst(), $urandom_range(0, 2) != 0,
                  $urandom_range(0, 30) == 0);
        end
        for (int k = 0; k < 4; k++) cycle(1'b0, 32'h0, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
